// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared LC-3b types used by the memory arbiter
// Line/word typedefs, arbiter FSM state encoding and a small state helper.
package lc3b_types;

  localparam int LC3B_LINE_W = 128;
  localparam int LC3B_ADDR_W = 16;

  typedef logic [LC3B_LINE_W-1:0] lc3b_line;
  typedef logic [LC3B_ADDR_W-1:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  function automatic logic arb_is_busy(input arb_state_t s);
    return (s == I_BUSY) || (s == D_BUSY);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - I-cache, D-cache and physical-memory port bundle
// master is the arbiter's view; slave is the caches/memory environment.
interface mem_arbiter_if #(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16
);

  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport master (
    input  i_read, i_addr,
    output i_rdata, i_resp,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_resp,
    output pmem_read, pmem_write, pmem_addr, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    output i_read, i_addr,
    input  i_rdata, i_resp,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_resp,
    input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/mem_arbiter_control.sv
// rtl/mem_arbiter_control.sv - arbiter FSM, grant selection and strobe flops
// ARB_RR_EN selects round-robin between simultaneous requesters; otherwise D beats I.
module mem_arbiter_control
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_read,
  input  logic       d_read,
  input  logic       d_write,
  input  logic       pmem_resp,
  output arb_state_t state,
  output logic       grant_i,
  output logic       grant_d,
  output logic       capture,
  output logic       pmem_read,
  output logic       pmem_write,
  output logic       i_resp,
  output logic       d_resp
);

  arb_state_t state_q, state_d;
  logic       read_q, read_d;
  logic       write_q, write_d;
  logic       owner_d_q, owner_d_d;
  logic       d_req;
  logic       pick_d;

  assign d_req = d_read | d_write;

`ifdef ARB_RR_EN
  // rr_q=1 means D is preferred on the next contended grant.
  logic rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (grant_i) begin
      rr_d = 1'b1;
    end else if (grant_d) begin
      rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign pick_d = (d_req && i_read) ? rr_q : d_req;
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d   = state_q;
    read_d    = read_q;
    write_d   = write_q;
    owner_d_d = owner_d_q;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    capture   = 1'b0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req || i_read) begin
          if (pick_d) begin
            // A simultaneous read+write is a writeback; the read is dropped.
            grant_d   = 1'b1;
            owner_d_d = 1'b1;
            write_d   = d_write;
            read_d    = ~d_write;
            state_d   = D_BUSY;
          end else begin
            grant_i   = 1'b1;
            owner_d_d = 1'b0;
            read_d    = 1'b1;
            write_d   = 1'b0;
            state_d   = I_BUSY;
          end
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) begin
          capture = 1'b1;
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        i_resp  = ~owner_d_q;
        d_resp  = owner_d_q;
        state_d = IDLE;
      end
      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      owner_d_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      read_q    <= read_d;
      write_q   <= write_d;
      owner_d_q <= owner_d_d;
    end
  end

  assign state      = state_q;
  assign pmem_read  = read_q  & arb_is_busy(state_q);
  assign pmem_write = write_q & arb_is_busy(state_q);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding I/D cache-line arbiter onto pmem
// Optional round-robin grant under ARB_RR_EN; default is fixed D-over-I priority.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int LINE_W = 128,
  parameter int ADDR_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);

  arb_state_t        state;
  logic              grant_i;
  logic              grant_d;
  logic              capture;
  logic              i_resp;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] line_q, line_d;

  mem_arbiter_control u_control (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_read     (bus.i_read),
    .d_read     (bus.d_read),
    .d_write    (bus.d_write),
    .pmem_resp  (bus.pmem_resp),
    .state      (state),
    .grant_i    (grant_i),
    .grant_d    (grant_d),
    .capture    (capture),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .i_resp     (i_resp),
    .d_resp     (d_resp)
  );

  // Requester inputs are only looked at on the grant cycle; afterwards the
  // memory port runs purely from these registers.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    line_d  = line_q;
    if (grant_d) begin
      addr_d  = bus.d_addr;
      wdata_d = bus.d_wdata;
    end else if (grant_i) begin
      addr_d  = bus.i_addr;
    end
    if (capture && arb_is_busy(state)) begin
      line_d = bus.pmem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      line_q  <= line_d;
    end
  end

  assign bus.pmem_read  = pmem_read;
  assign bus.pmem_write = pmem_write;
  assign bus.pmem_addr  = addr_q;
  assign bus.pmem_wdata = wdata_q;
  assign bus.i_rdata    = line_q;
  assign bus.d_rdata    = line_q;
  assign bus.i_resp     = i_resp;
  assign bus.d_resp     = d_resp;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized bench for mem_arbiter
// Expected winners come from a request-level arbitration model (ARB_RR_EN aware).
module tb_mem_arbiter;
  import lc3b_types::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  bit   prefer_d;

  mem_arbiter_if #(.LINE_W(128), .ADDR_W(16)) bus ();

  mem_arbiter #(.LINE_W(128), .ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic lc3b_line rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Memory side: wait for a strobe, hold it lat cycles, then return rdata.
  task automatic serve(input bit exp_d, input bit exp_wr, input logic [15:0] exp_addr,
                       input logic [127:0] exp_wd, input int lat,
                       input logic [127:0] rdata, input bit chg);
    int n;
    n = 0;
    while (!(bus.pmem_read || bus.pmem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("strobe_seen", {127'd0, n < 20}, 128'd1);
    for (int c = 1; c <= lat; c++) begin
      chk("pmem_read", {127'd0, bus.pmem_read}, {127'd0, !exp_wr});
      chk("pmem_write", {127'd0, bus.pmem_write}, {127'd0, exp_wr});
      chk("pmem_addr", {112'd0, bus.pmem_addr}, {112'd0, exp_addr});
      if (exp_wr) chk("pmem_wdata", bus.pmem_wdata, exp_wd);
      chk("resp_busy", {126'd0, bus.i_resp, bus.d_resp}, 128'd0);
      if (chg && c == 1) begin
        bus.i_addr  = bus.i_addr ^ 16'h00c0;
        bus.d_addr  = bus.d_addr ^ 16'h0ff0;
        bus.d_wdata = ~bus.d_wdata;
      end
      if (c == lat) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rdata;
      end
      @(negedge clk);
    end
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = rand_line();
    chk("strobe_done", {126'd0, bus.pmem_read, bus.pmem_write}, 128'd0);
    chk("i_resp", {127'd0, bus.i_resp}, {127'd0, !exp_d});
    chk("d_resp", {127'd0, bus.d_resp}, {127'd0, exp_d});
    chk("rdata", exp_d ? bus.d_rdata : bus.i_rdata, rdata);
  endtask

  // One arbitration round from the currently held requests.
  task automatic arb_round(input int lat, input bit chg);
    bit win_d;
    win_d = (bus.d_read || bus.d_write) && (!bus.i_read || prefer_d);
`ifdef ARB_RR_EN
    prefer_d = !win_d;
`endif
    serve(win_d, win_d && bus.d_write, win_d ? bus.d_addr : bus.i_addr,
          bus.d_wdata, lat, rand_line(), chg);
    if (win_d) begin
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
    end else begin
      bus.i_read = 1'b0;
    end
    @(negedge clk);
    chk("idle_strobe", {126'd0, bus.pmem_read, bus.pmem_write}, 128'd0);
    chk("resp_once", {126'd0, bus.i_resp, bus.d_resp}, 128'd0);
  endtask

  function automatic bit reset_pref();
`ifdef ARB_RR_EN
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  initial begin
    int n;
    int kind;
    errors = 0;
    checks = 0;
    prefer_d = reset_pref();
    rst_n = 1'b0;
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_strobes", {126'd0, bus.pmem_read, bus.pmem_write}, 128'd0);
    chk("rst_resps", {126'd0, bus.i_resp, bus.d_resp}, 128'd0);
    chk("rst_addr", {112'd0, bus.pmem_addr}, 128'd0);
    chk("rst_wdata", bus.pmem_wdata, 128'd0);
    chk("rst_line", bus.i_rdata, 128'd0);
    rst_n = 1'b1;

    // Single I read, address change mid-transaction, A5 line after 3 cycles.
    bus.i_read = 1'b1; bus.i_addr = 16'h0040;
    serve(1'b0, 1'b0, 16'h0040, '0, 3, {16{8'hA5}}, 1'b1);
    bus.i_read = 1'b0;
    @(negedge clk);
    chk("i_single_idle", {126'd0, bus.i_resp, bus.d_resp}, 128'd0);

    // D writeback.
    bus.d_write = 1'b1; bus.d_addr = 16'h1230; bus.d_wdata = 128'h1;
    arb_round(4, 1'b0);

    // Simultaneous reads, then repeated contention.
    bus.i_read = 1'b1; bus.i_addr = 16'h0100;
    bus.d_read = 1'b1; bus.d_addr = 16'h0200;
    arb_round(2, 1'b0);
    arb_round(1, 1'b0);
    for (int r = 0; r < 4; r++) begin
      if (!bus.i_read) begin bus.i_read = 1'b1; bus.i_addr = 16'($urandom()); end
      if (!bus.d_read) begin bus.d_read = 1'b1; bus.d_addr = 16'($urandom()); end
      arb_round(1 + r, 1'b0);
    end
    if (bus.i_read || bus.d_read) arb_round(2, 1'b0);

    // D requests back-to-back while I waits.
    bus.i_read = 1'b1; bus.i_addr = 16'h0300;
    for (int r = 0; r < 3; r++) begin
      if (!bus.d_read) begin bus.d_read = 1'b1; bus.d_addr = 16'($urandom()); end
      arb_round(2, 1'b0);
    end
    if (bus.i_read || bus.d_read) arb_round(1, 1'b0);
    if (bus.i_read || bus.d_read) arb_round(1, 1'b0);

    // Reset while a writeback is in flight.
    bus.d_write = 1'b1; bus.d_addr = 16'h2220; bus.d_wdata = rand_line();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.pmem_write && n < 20);
    chk("rst_mid_seen", {127'd0, bus.pmem_write}, 128'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_write", {127'd0, bus.pmem_write}, 128'd0);
    chk("rst_mid_resp", {126'd0, bus.i_resp, bus.d_resp}, 128'd0);
    chk("rst_mid_line", bus.d_rdata, 128'd0);
    chk("rst_mid_addr", {112'd0, bus.pmem_addr}, 128'd0);
    prefer_d = reset_pref();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    arb_round(2, 1'b0);

    // Randomized traffic.
    for (int r = 0; r < 24; r++) begin
      if (!bus.i_read && ($urandom_range(0, 1) == 1)) begin
        bus.i_read = 1'b1; bus.i_addr = 16'($urandom());
      end
      if (!(bus.d_read || bus.d_write) && ($urandom_range(0, 1) == 1)) begin
        kind = int'($urandom_range(0, 2));
        bus.d_read  = (kind != 1);
        bus.d_write = (kind != 0);
        bus.d_addr  = 16'($urandom());
        bus.d_wdata = rand_line();
      end
      if (!(bus.i_read || bus.d_read || bus.d_write)) begin
        bus.i_read = 1'b1; bus.i_addr = 16'($urandom());
      end
      arb_round(int'($urandom_range(1, 5)), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single physical-memory port between the instruction-cache miss path (fetch side) and the data-cache miss path (memory stage) of the LC-3b pipeline. Exactly one cache-line transaction is outstanding at a time. The arbiter latches the winning request, drives the memory port from registers, and returns the line to the winner with a one-cycle response pulse.

## Interface
Parameters:
- LINE_W, 128, cache line width in bits
- ADDR_W, 16, byte address width (lc3b_word)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- i_read  in  1  I-side line read request; held until i_resp
- i_addr  in  ADDR_W  I-side line address
- i_rdata  out  LINE_W  I-side returned line; valid while i_resp=1
- i_resp  out  1  I-side completion pulse, one cycle
- d_read  in  1  D-side line read request; held until d_resp
- d_write  in  1  D-side line write (writeback) request; held until d_resp
- d_addr  in  ADDR_W  D-side line address
- d_wdata  in  LINE_W  D-side write line
- d_rdata  out  LINE_W  D-side returned line; valid while d_resp=1
- d_resp  out  1  D-side completion pulse, one cycle
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_addr  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write data
- pmem_rdata  in  LINE_W  memory read data; sampled when pmem_resp=1
- pmem_resp  in  1  memory completion pulse

## Operation
- FSM states: IDLE, I_BUSY, D_BUSY, DONE.
- IDLE: with no request, stay. Otherwise grant one requester, latch its addr (and d_wdata and the read/write kind for D), then go to I_BUSY or D_BUSY.
- Grant policy (default): D has fixed priority over I.
- d_read and d_write both high: treated as a write; d_read is ignored.
- I_BUSY/D_BUSY: pmem_read or pmem_write is held high, and pmem_addr/pmem_wdata come from the latched registers, until pmem_resp. On pmem_resp, capture pmem_rdata into the line register and go to DONE.
- DONE: assert the granted side's resp for exactly one cycle, with rdata driven from the line register. The other side's resp stays 0. Then go to IDLE.
- Requester inputs are not sampled outside IDLE. Request changes mid-transaction are ignored.
- i_rdata and d_rdata both show the line register. Only the resp qualifies them.
- Reset (asynchronous, any state): state=IDLE; pmem_read=pmem_write=0; i_resp=d_resp=0; address, wdata and line registers cleared to 0; round-robin pointer cleared to 0 (I-preferred next).

## Timing
- A request seen in IDLE at edge t puts the pmem strobe high from t+1.
- pmem_resp sampled at edge k puts the strobe low and resp=1 during cycle k+1. The FSM is back in IDLE at k+2.
- Overhead is 2 cycles plus memory latency. The earliest next grant is at edge k+2, so one dead cycle lets the served client drop its request.
- The strobe is never high in IDLE or DONE. pmem_read and pmem_write are never high together.

## Configuration
- ARB_RR_EN defined: round-robin when both sides request in IDLE. A 1-bit pointer selects the winner and flips to the other side after each grant. A lone request always wins regardless of the pointer.
- ARB_RR_EN undefined: fixed D-over-I priority and no pointer flop. I can starve while D requests back-to-back.

## Structure
- Shared package lc3b_types (existing) gains:
  - lc3b_line (LINE_W-bit line typedef)
  - arb_state_t enum {IDLE, I_BUSY, D_BUSY, DONE}
- One sub-module, mem_arbiter_control: the FSM, grant logic and RR pointer.
- The top level holds the address/wdata/line registers and output muxing.

## Test plan
- Single I read only: i_read=1, i_addr=16'h0040, memory returns 128'hA5…A5 after 3 cycles -> pmem_read high 3 cycles, pmem_addr=16'h0040; i_resp high exactly 1 cycle with i_rdata=128'hA5…A5; d_resp stays 0.
- D write: d_write=1, d_addr=16'h1230, d_wdata=128'h1 -> pmem_write=1 with pmem_addr=16'h1230 and pmem_wdata=128'h1 until pmem_resp; then d_resp pulse; pmem_read never high.
- Simultaneous requests: i_read and d_read rise in the same cycle -> D served first and I second. With ARB_RR_EN from reset, I is served first; on repeated contention the winners alternate I, D, I, D.
- Starvation check: D requests continuously with I pending -> without ARB_RR_EN, I is never granted. With ARB_RR_EN, I is granted within 2 transactions.
- Reset mid-transaction: rst_n low during D_BUSY -> pmem_write=0 immediately with no clock edge; after release the FSM is in IDLE, no resp pulse is issued, and a held request is re-granted.
- Request change mid-transaction: i_addr changes from 16'h0040 to 16'h0080 during I_BUSY -> pmem_addr stays 16'h0040.
